// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types, widths and the code-to-voltage transfer function for dac_8bit_sh
package dac_pkg;

  localparam int CODE_W   = 8;
  localparam int ANALOG_W = 64;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_e;

  // Bin centre of the matching flash ADC, so a DAC->ADC round trip is lossless.
  function automatic real code_to_volts(input logic [CODE_W-1:0] code, input real vmin,
                                        input real vmax);
    real lsb;
    lsb = (vmax - vmin) / 256.0;
    return vmin + (real'(int'(code)) + 0.5) * lsb;
  endfunction

endpackage

// File: rtl/dac_slew_limiter.sv
// rtl/dac_slew_limiter.sv - registered real follower that moves toward its target by at most step per cycle
module dac_slew_limiter (
  input  logic clk,
  input  logic rst,
  input  real  target,
  input  real  step,
  output real  value,
  output logic at_target
);

  real value_q;
  real value_d;
  real target_q;
  real target_d;
  real diff;

  always_comb begin
    diff     = target - value_q;
    target_d = target;
    if (diff > step) begin
      value_d = value_q + step;
    end else if (diff < -step) begin
      value_d = value_q - step;
    end else begin
      value_d = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q  <= 0.0;
      target_q <= 0.0;
    end else begin
      value_q  <= value_d;
      target_q <= target_d;
    end
  end

  // Flag compares registered state only, so it never depends on this cycle's target input.
  assign value     = value_q;
  assign at_target = (value_q == target_q);

endmodule

// File: rtl/dac_8bit_sh.sv
// rtl/dac_8bit_sh.sv - 8-bit sample-and-hold DAC model; optional slew limiting under DAC_SLEW_EN
module dac_8bit_sh
  import dac_pkg::*;
#(
  parameter real VMIN          = -11.0,
  parameter real VMAX          = 11.0,
  parameter int  SETTLE_CYCLES = 4,
  parameter real SLEW_STEP     = 0.5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:1]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [64:1] analog_out,
  output logic [8:1]  code_q,
  output logic        settled
);

  state_e            state_q;
  state_e            state_d;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [CODE_W-1:0] code_d;
  logic              settled_d;
  real               target_q;
  real               target_d;
  real               value;
  logic              at_target;
  logic              accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    settled_d = settled;
    target_d  = target_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          accept = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        if (cnt_d == 8'd0 && at_target) begin
          // A code waiting on the completion edge is taken there, keeping full throughput.
          if (din_valid) begin
            accept = 1'b1;
          end else begin
            state_d   = IDLE;
            settled_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      code_d    = din;
      target_d  = code_to_volts(din, VMIN, VMAX);
      cnt_d     = 8'(SETTLE_CYCLES);
      state_d   = SETTLE;
      settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      code_q   <= 8'h00;
      settled  <= 1'b0;
      target_q <= 0.0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      settled  <= settled_d;
      target_q <= target_d;
    end
  end

`ifdef DAC_SLEW_EN
  dac_slew_limiter u_slew (
    .clk       (clk),
    .rst       (rst),
    .target    (target_d),
    .step      (SLEW_STEP),
    .value     (value),
    .at_target (at_target)
  );
`else
  real value_q;
  real value_d;

  always_comb begin
    value_d = accept ? target_d : value_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= 0.0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  assign at_target = (value_q == target_q);
`endif

  assign din_ready  = (state_q == IDLE);
  assign analog_out = $realtobits(value);

endmodule

// File: tb/tb_dac_8bit_sh.sv
// tb/tb_dac_8bit_sh.sv - directed self-checking bench for dac_8bit_sh (default build and DAC_SLEW_EN)
module tb_dac_8bit_sh;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:1]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [64:1] analog_out;
  logic [8:1]  code_q;
  logic        settled;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam real V0   = -10.95703125;
  localparam real V128 = 0.04296875;
  localparam real V255 = 10.95703125;
  localparam real V200 = 6.23046875;

  dac_8bit_sh dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .analog_out (analog_out),
    .code_q     (code_q),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!din_ready && n < 200) begin
      tick();
      n++;
    end
    total_cnt++;
    if (!din_ready) $display("FAIL %s ready timeout got din_ready=%b required 1", name, din_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    total_cnt++;
    if (analog_out !== 64'h0) $display("FAIL reset_analog got %h required 0", analog_out);
    else pass_cnt++;
    total_cnt++;
    if (din_ready !== 1'b1) $display("FAIL reset_ready got %b required 1", din_ready);
    else pass_cnt++;
    total_cnt++;
    if (settled !== 1'b0) $display("FAIL reset_settled got %b required 0", settled);
    else pass_cnt++;
    total_cnt++;
    if (code_q !== 8'h00) $display("FAIL reset_code got %h required 00", code_q);
    else pass_cnt++;
  endtask

`ifndef DAC_SLEW_EN
  task automatic test_single();
    din = 8'd128;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    total_cnt++;
    if (analog_out !== $realtobits(V128))
      $display("FAIL single_analog got %f required %f", $bitstoreal(analog_out), V128);
    else pass_cnt++;
    total_cnt++;
    if ({din_ready, settled, code_q} !== {1'b0, 1'b0, 8'd128})
      $display("FAIL single_flags got rdy=%b set=%b code=%0d required 0 0 128", din_ready, settled, code_q);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if ({din_ready, settled} !== 2'b00)
      $display("FAIL single_early got rdy=%b set=%b required 0 0", din_ready, settled);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({din_ready, settled} !== 2'b11)
      $display("FAIL single_settle got rdy=%b set=%b required 1 1", din_ready, settled);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    din = 8'd0;
    din_valid = 1'b1;
    tick();
    din = 8'd255;
    total_cnt++;
    if (analog_out !== $realtobits(V0) || code_q !== 8'd0)
      $display("FAIL b2b_first got %f code %0d required %f code 0", $bitstoreal(analog_out), code_q, V0);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (code_q !== 8'd0) $display("FAIL b2b_hold got code %0d required 0", code_q);
    else pass_cnt++;
    tick();
    din = 8'd0;
    total_cnt++;
    if (analog_out !== $realtobits(V255) || code_q !== 8'd255 || settled !== 1'b0)
      $display("FAIL b2b_second got %f code %0d set %b required %f code 255 set 0",
               $bitstoreal(analog_out), code_q, settled, V255);
    else pass_cnt++;
    repeat (4) tick();
    din_valid = 1'b0;
    total_cnt++;
    if (analog_out !== $realtobits(V0) || code_q !== 8'd0 || settled !== 1'b0 || din_ready !== 1'b0)
      $display("FAIL b2b_third got %f code %0d set %b rdy %b required %f code 0 set 0 rdy 0",
               $bitstoreal(analog_out), code_q, settled, din_ready, V0);
    else pass_cnt++;
    repeat (4) tick();
    total_cnt++;
    if ({din_ready, settled} !== 2'b11)
      $display("FAIL b2b_end got rdy=%b set=%b required 1 1", din_ready, settled);
    else pass_cnt++;
  endtask
`else
  task automatic test_slew();
    int n;
    din = 8'd0;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    wait_ready("slew_pre");
    din = 8'd255;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    total_cnt++;
    if (analog_out !== $realtobits(-10.45703125))
      $display("FAIL slew_first got %f required -10.45703125", $bitstoreal(analog_out));
    else pass_cnt++;
    repeat (42) tick();
    total_cnt++;
    if (analog_out !== $realtobits(10.54296875) || settled !== 1'b0)
      $display("FAIL slew_prelast got %f set %b required 10.54296875 set 0", $bitstoreal(analog_out), settled);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (analog_out !== $realtobits(V255) || settled !== 1'b0)
      $display("FAIL slew_last got %f set %b required %f set 0", $bitstoreal(analog_out), settled, V255);
    else pass_cnt++;
    n = 43;
    while (!settled && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n !== 44) $display("FAIL slew_cycles got %0d required 44", n);
    else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    wait_ready("mid_pre");
    din = 8'd77;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({analog_out, code_q, settled, din_ready} !== {64'h0, 8'h00, 1'b0, 1'b1})
      $display("FAIL mid_reset got %h code %h set %b rdy %b required 0 00 0 1",
               analog_out, code_q, settled, din_ready);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    din = 8'd200;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    total_cnt++;
    if (code_q !== 8'd200 || din_ready !== 1'b0)
      $display("FAIL mid_accept got code %0d rdy %b required 200 0", code_q, din_ready);
    else pass_cnt++;
`ifndef DAC_SLEW_EN
    total_cnt++;
    if (analog_out !== $realtobits(V200))
      $display("FAIL mid_analog got %f required %f", $bitstoreal(analog_out), V200);
    else pass_cnt++;
`endif
  endtask

  task automatic test_round_trip();
    int  adc;
    real v;
    for (int i = 0; i < 256; i++) begin
      wait_ready("rt_ready");
      din = 8'(i);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      wait_ready("rt_settle");
      v = $bitstoreal(analog_out);
      adc = $rtoi((v + 11.0) / 0.0859375);
      if (adc > 255) adc = 255;
      if (adc < 0) adc = 0;
      total_cnt++;
      if (adc !== i || code_q !== 8'(i))
        $display("FAIL round_trip got adc %0d code_q %0d required %0d", adc, code_q, i);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
`ifndef DAC_SLEW_EN
    test_single();
    test_back_to_back();
`else
    test_slew();
`endif
    test_reset_mid();
    test_round_trip();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dac_8bit_sh.md
# dac_8bit_sh

Clocked 8-bit sample-and-hold DAC model. It is the reverse path of the 8-bit flash ADC: it accepts an 8-bit code over a valid/ready handshake and drives a reconstructed voltage as a 64-bit `$realtobits` bus, the same encoding the ADC consumes. It holds each sample for a programmable settling interval before accepting the next one. Use it for ADC→DAC round-trip benches and as the analog stimulus source in mixed-signal loops.

## Interface
- `VMIN`, default -11.0 (real): bottom of the full-scale range, in V.
- `VMAX`, default 11.0 (real): top of the full-scale range, in V.
- `SETTLE_CYCLES`, default 4: minimum cycles from code acceptance to `settled`. Legal range 1..255.
- `SLEW_STEP`, default 0.5 (real): maximum output change per cycle, in V. Used only with `DAC_SLEW_EN`.
- `clk` input, 1 bit: rising-edge clock.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `din` input, [8:1]: DAC code.
- `din_valid` input, 1 bit: `din` is valid this cycle.
- `din_ready` output, 1 bit: the block can accept a code.
- `analog_out` output, [64:1]: output voltage, `$realtobits` encoding.
- `code_q` output, [8:1]: the code currently being reconstructed.
- `settled` output, 1 bit: `analog_out` is final for `code_q`.

## Operation
- Transfer function:
  - LSB = (VMAX − VMIN)/256.
  - target = VMIN + (code + 0.5)·LSB, which is the ADC bin centre.
  - With the defaults, LSB = 0.0859375. Code 0 → −10.95703125, 128 → 0.04296875, 255 → 10.95703125.
- State machine: IDLE, SETTLE.
  - IDLE: `din_ready`=1. If `din_valid` is high, latch `din` into `code_q`, compute target, load the counter with SETTLE_CYCLES, and go to SETTLE.
  - SETTLE: `din_ready`=0. The counter decrements every cycle. Go to IDLE when the counter reaches 0 and the output equals target.
- `settled` is 0 from the acceptance edge until the SETTLE→IDLE edge, then 1 until the next acceptance.
- `din_valid` in SETTLE is ignored. No queuing; the source must hold the code until `din_ready` is high.
- Back-to-back: a code presented while in IDLE on the same cycle the block returns to IDLE is accepted on that edge. `settled` then pulses 0 with no 1-cycle gap.
- Arithmetic is done in `real` internally. `analog_out` is always the `$realtobits` of the held real value. `code_q` is unsigned 8-bit; there is no clamping because every code maps inside [VMIN, VMAX].
- Reset, asynchronous and including mid-SETTLE: state=IDLE, `analog_out`=64'h0 (0.0 V), `code_q`=8'h00, `settled`=0, `din_ready`=1, counter=0. Any in-flight code is discarded.

## Timing
- Acceptance at edge N (`din_valid` & `din_ready`). After edge N: `din_ready`=0, `settled`=0, `code_q`=din.
- Without slew:
  - `analog_out`=target after edge N (latency 1).
  - `settled`=1 and `din_ready`=1 after edge N+SETTLE_CYCLES.
  - Throughput is one code per SETTLE_CYCLES cycles.
- With slew: `analog_out` moves toward target by min(SLEW_STEP, |diff|) at each edge from N onward. `settled` is asserted at the first edge where the counter is 0 and the output equals target, so settling takes max(SETTLE_CYCLES, ceil(|Δ|/SLEW_STEP)) cycles.

## Configuration
- `DAC_SLEW_EN` defined: the output is slew-limited as described in Timing; `SLEW_STEP` is active.
- `DAC_SLEW_EN` undefined: the output steps to target at the acceptance edge; `SLEW_STEP` is unused.
- Port list and handshake are identical in both builds.

## Structure
- Package `dac_pkg`:
  - state enum {IDLE, SETTLE};
  - function `code_to_volts(code, vmin, vmax)` returning real;
  - width constant CODE_W=8 and bus constant ANALOG_W=64.
- Sub-module `dac_slew_limiter`: registered real follower with inputs target and step, outputs the current value and an at_target flag. It is instantiated only under `DAC_SLEW_EN`.

## Test plan
- Reset release, then idle 5 cycles → `analog_out`=64'h0, `din_ready`=1, `settled`=0, `code_q`=0.
- No slew, SETTLE_CYCLES=4, `din`=128 accepted at edge N → `analog_out`=0.04296875 after N; `settled` and `din_ready` rise after N+4.
- No slew, codes 0, 255, 0 held valid continuously → outputs −10.95703125, 10.95703125, −10.95703125; acceptances are exactly 4 cycles apart.
- Slew, code 0 then 255 → output rises by 0.5 per cycle; `settled` goes high after 44 cycles (Δ = 21.9140625); the last step is 0.4140625.
- `rst` pulsed 2 cycles into SETTLE → all outputs return to reset values immediately; the next code is accepted on the first edge after release.
- Round trip through the ADC, sweeping codes 0..255 → ADC output code equals `code_q` for every code.
